// File: rtl/ifmap_unpack_ctrl.sv
// Ifmap word-to-byte unpack controller: fetches num_words words and streams their bytes LSB first.
// Define IFMAP_PREFETCH_EN to add a one-word prefetch that removes the inter-word bubbles.
module ifmap_unpack_ctrl #(
    parameter int BUS    = 31,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BUS:0]      mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last
);

    localparam int BPW   = (BUS + 1) / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   count;
    logic [BUS:0]       word_reg;
    logic [IDX_W-1:0]   byte_idx;
    logic               hs, last_byte, more, pf_issue;

    assign hs        = (state == SHIFT) && out_ready;
    assign last_byte = (byte_idx == IDX_W'(BPW - 1));
    assign more      = (count > LEN_W'(1));

`ifdef IFMAP_PREFETCH_EN
    logic         pf_valid, pf_pending, pf_issued;
    logic [BUS:0] pf_data;

    assign pf_issue = (state == SHIFT) && (byte_idx == '0) && more && !pf_issued;

    // Data still in flight at the last-byte handshake is taken straight from the bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
            pf_issued  <= 1'b0;
        end else begin
            pf_pending <= pf_issue;
            if (pf_issue)
                pf_issued <= 1'b1;
            if (hs && last_byte) begin
                pf_issued <= 1'b0;
                pf_valid  <= 1'b0;
            end else if (pf_pending && state == SHIFT) begin
                pf_valid <= 1'b1;
                pf_data  <= mem_rd_data;
            end
        end
    end
`else
    assign pf_issue = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_words != '0) ? FETCH : DONE;
            FETCH: state_nxt = WAIT;
            WAIT:  state_nxt = SHIFT;
            SHIFT: begin
                if (hs && last_byte) begin
                    if (!more)
                        state_nxt = DONE;
`ifdef IFMAP_PREFETCH_EN
                    else if (pf_valid || pf_pending)
                        state_nxt = SHIFT;
                    else if (pf_issue)
                        state_nxt = WAIT;
`endif
                    else
                        state_nxt = FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr     <= '0;
            count    <= '0;
            word_reg <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && num_words != '0) begin
                        addr  <= base_addr;
                        count <= num_words;
                    end
                end
                WAIT: begin
                    word_reg <= mem_rd_data;
                    byte_idx <= '0;
                end
                SHIFT: begin
                    if (hs && !last_byte) begin
                        word_reg <= word_reg >> 8;
                        byte_idx <= byte_idx + IDX_W'(1);
                    end else if (hs && more) begin
                        addr  <= addr + ADDR_W'(1);
                        count <= count - LEN_W'(1);
`ifdef IFMAP_PREFETCH_EN
                        if (pf_valid || pf_pending) begin
                            word_reg <= pf_valid ? pf_data : mem_rd_data;
                            byte_idx <= '0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by reset so they read zero for the whole reset window.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        if (rst) begin
            busy      = (state == FETCH) || (state == WAIT) || (state == SHIFT);
            done      = (state == DONE);
            out_valid = (state == SHIFT);
            if (state == FETCH) begin
                mem_rd_en = 1'b1;
                mem_addr  = addr;
            end else if (pf_issue) begin
                mem_rd_en = 1'b1;
                mem_addr  = addr + ADDR_W'(1);
            end
            if (state == SHIFT) begin
                out_byte = word_reg[7:0];
                out_last = last_byte && !more;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_unpack_ctrl.sv
// Self-checking bench for ifmap_unpack_ctrl: byte-queue reference model, randomized memory and backpressure.
module tb_ifmap_unpack_ctrl;

    localparam int BUS    = 31;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int BPW    = (BUS + 1) / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_words;
    logic              busy, done, mem_rd_en, out_valid, out_ready, out_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS:0]      mem_rd_data;
    logic [7:0]        out_byte;

    logic [BUS:0]      mem [0:(1<<ADDR_W)-1];
    logic [7:0]        exp_bytes [$];
    logic [ADDR_W-1:0] exp_addrs [$];

    int vectors = 0;
    int miscompares = 0;

    ifmap_unpack_ctrl #(.BUS(BUS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // SRAM model: data valid one cycle after the read strobe
    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, mem_rd_en, mem_addr, out_valid, out_byte, out_last};
    endfunction

    // mode 0: ready always high, 1: random ready, 2: stall 3 cycles on the second byte
    task automatic run_xfer(input logic [ADDR_W-1:0] b, input int n, input int mode, input bit poke);
        int          j, hs_cnt, stalls, exp_done;
        bit          got_done, prev_stall;
        logic [7:0]  prev_byte;
        logic        prev_last;
        logic [BUS:0] w;
        exp_bytes.delete();
        exp_addrs.delete();
        for (int i = 0; i < n; i++) begin
            exp_addrs.push_back(ADDR_W'(b + i));
            w = mem[ADDR_W'(b + i)];
            for (int k = 0; k < BPW; k++) exp_bytes.push_back(w[8*k +: 8]);
        end
`ifdef IFMAP_PREFETCH_EN
        exp_done = (n == 0) ? 1 : 3 + n * BPW;
`else
        exp_done = (n == 0) ? 1 : 1 + n * (BPW + 2);
`endif
        start = 1'b1; base_addr = b; num_words = LEN_W'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); num_words = LEN_W'($urandom);
        j = 1; hs_cnt = 0; stalls = 0; got_done = 0; prev_stall = 0;
        prev_byte = '0; prev_last = 1'b0;
        while (!got_done && j < 400) begin
            if (mem_rd_en) begin
                if (exp_addrs.size() == 0) check("extra_read", 1, 0);
                else check("rd_addr", mem_addr, exp_addrs.pop_front());
            end
            if (j == 1 && n > 0) begin
                check("rd_en_T1", mem_rd_en, 1);
                check("busy_T1", busy, 1);
            end
            if (j == 3 && n > 0) check("valid_T3", out_valid, 1);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_byte", out_byte, prev_byte);
                check("hold_last", out_last, prev_last);
            end
            if (done) begin
                got_done = 1;
                check("done_empty", exp_bytes.size(), 0);
                check("done_busy", busy, 0);
                if (mode == 0) check("done_time", j, exp_done);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = !(out_valid && hs_cnt == 1 && stalls < 3);
                    if (!out_ready) stalls++;
                end
            endcase
            if (poke && j == 4) begin
                start = 1'b1; base_addr = ADDR_W'($urandom); num_words = LEN_W'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_bytes.size() == 0) check("extra_byte", 1, 0);
                else begin
                    check("byte", out_byte, exp_bytes.pop_front());
                    check("last", out_last, exp_bytes.size() == 0);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            prev_last  = out_last;
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        check("reads_left", exp_addrs.size(), 0);
        check("done_pulse", done, 0);
        if (mode == 2) check("stalls", stalls, 3);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = BUS'($urandom);
        mem[10'h010] = 32'h44332211;
        mem[10'h020] = 32'h04030201;
        mem[10'h021] = 32'h08070605;
        mem[10'h022] = 32'h0C0B0A09;

        rst = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        run_xfer(10'h010, 1, 0, 0);
        run_xfer(10'h010, 1, 2, 0);
        run_xfer(10'h020, 3, 0, 0);
        run_xfer(10'h123, 0, 0, 0);
        run_xfer(10'h020, 3, 0, 1);
        run_xfer(10'h3FF, 2, 0, 0);

        // reset in the middle of a transfer
        start = 1'b1; base_addr = 10'h100; num_words = 2; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_valid", out_valid, 1);
        rst = 1'b0;
        #1 check("rst_outs_now", all_outs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_outs", all_outs(), 0);
        end
        rst = 1'b1;
        #1 check("post_rst_idle", all_outs(), 0);
        @(negedge clk);
        check("post_rst_idle2", all_outs(), 0);
        run_xfer(10'h000, 1, 0, 0);

        for (int t = 0; t < 25; t++)
            run_xfer(ADDR_W'($urandom), $urandom_range(1, 5), (t % 4 == 0) ? 0 : 1, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifmap_unpack_ctrl.md
# ifmap_unpack_ctrl

Controller that sequences the ifmap word-to-byte unpacking path. On a start command it fetches `num_words` consecutive words from the ifmap buffer memory and splits each word into bytes, least-significant byte first. It delivers the bytes to the PE array over a valid/ready stream, then pulses `done`. It sits between the ifmap SRAM read port and the PE-array ifmap input, and replaces free-running enable-driven unpacking with a handshaked, length-bounded transfer.

## Interface
- `BUS`, 31: MSB index of the memory word; word width is BUS+1, which must be a multiple of 8. BPW = (BUS+1)/8 bytes per word.
- `ADDR_W`, 10: memory address width.
- `LEN_W`, 10: width of the word-count field.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; latched with `start`.
- `num_words`  in  LEN_W  words to transfer; latched with `start`.
- `busy`  out  1  high in FETCH/WAIT/SHIFT.
- `done`  out  1  one-cycle pulse in DONE.
- `mem_rd_en`  out  1  read strobe to the ifmap SRAM.
- `mem_addr`  out  ADDR_W  read address, valid with `mem_rd_en`.
- `mem_rd_data`  in  BUS+1  read data; valid exactly 1 cycle after `mem_rd_en`.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  consumer accepts the byte.
- `out_byte`  out  8  current byte.
- `out_last`  out  1  marks the final byte of the final word; qualified by `out_valid`.

## Operation
- States: IDLE, FETCH, WAIT, SHIFT, DONE.
- **IDLE**
  - `start`=1 and `num_words`>0: latch address and count, go to FETCH.
  - `start`=1 and `num_words`=0: go to DONE; no memory read is issued.
- **FETCH:** `mem_rd_en`=1 with `mem_addr`=current address. Go to WAIT.
- **WAIT:** load the word register from `mem_rd_data`, clear the byte index, go to SHIFT.
- **SHIFT**
  - `out_valid`=1, `out_byte`=word_reg[7:0].
  - On handshake (`out_valid`&`out_ready`): shift word_reg right by 8 and increment the byte index.
  - After the handshake on byte BPW-1:
    - if words remain: address+1, count-1, go to FETCH;
    - else go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Stream rules**
  - `out_byte` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
  - Each byte is delivered exactly once.
  - `out_ready` is ignored outside SHIFT.
- `start` is ignored while not in IDLE. Address increments wrap modulo 2^ADDR_W.
- Reset (`rst`=0) at any cycle, including mid-transfer:
  - next state IDLE;
  - all outputs 0;
  - a read in flight is discarded;
  - word register contents are don't-care.

## Timing
- All outputs are 0 under reset.
- `start` sampled at edge T:
  - `mem_rd_en` at T+1;
  - first `out_valid` at T+3.
- With `out_ready` held high:
  - one byte per cycle within a word;
  - 2 bubble cycles between words (FETCH+WAIT), i.e. BPW+2 cycles per word.
- `done` asserts the cycle after the final handshake.
- With `num_words`=0, `done` asserts at T+1.

## Configuration
- `IFMAP_PREFETCH_EN` defined: adds a one-word prefetch register and valid flag.
  - On the first SHIFT cycle of any non-final word, issue `mem_rd_en` for address+1.
  - Capture the returned data one cycle later into the prefetch register.
  - On the handshake of byte BPW-1, if the prefetch is valid, load it straight into the word register and stay in SHIFT. The result is zero inter-word bubbles with `out_ready` high.
  - If the last-byte handshake happens in the same cycle the prefetch read is issued (BPW=1), go to WAIT and load from `mem_rd_data` there.
  - Reset clears the prefetch valid flag.
- `IFMAP_PREFETCH_EN` not defined: no prefetch register; behaviour exactly as in Operation/Timing above.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles mid-SHIFT -> all outputs 0, state IDLE. Then a new `start` with base 0, 1 word -> `mem_rd_en` 1 cycle later.
- **Single word:** BPW=4, `num_words`=1, base 0x010, memory[0x010]=0x44332211, `out_ready`=1.
  - `mem_addr`=0x010 at T+1.
  - Bytes 0x11,0x22,0x33,0x44 at T+3..T+6, with `out_last` only at T+6.
  - `done` at T+7.
- **Backpressure:** same setup, `out_ready` low for 3 cycles while 0x22 is presented -> 0x22 held stable. The stream is still 11,22,33,44 with no loss or duplication.
- **Multi-word:** 3 words 0x04030201, 0x08070605, 0x0C0B0A09, `out_ready`=1 -> bytes 0x01..0x0C in order.
  - Without `IFMAP_PREFETCH_EN`: 2-cycle gap between words, done at T+19.
  - With `IFMAP_PREFETCH_EN`: 12 contiguous bytes, done at T+15.
- **Zero length / ignored start:**
  - `num_words`=0 -> `done` at T+1, `mem_rd_en` never asserted.
  - `start` pulsed again while `busy` -> no effect on address, count or stream.
- **Address wrap:** base 0x3FF, 2 words, ADDR_W=10 -> reads at 0x3FF then 0x000.
